// File: rtl/pwm_multich_core_if.sv
// Register bus between a host and the PWM core.
// The host drives strobes, address and write data; the core returns rdata.
interface pwm_multich_core_if;
   logic        wr_en;
   logic        rd_en;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output wr_en, rd_en, addr, wdata,
      input  rdata
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata,
      output rdata
   );
endinterface

// File: rtl/pwm_multich_core.sv
// Multi-channel PWM: shadowed period/duty, edge or center counting,
// per-channel deadtime and a latched fault shutdown.
module pwm_multich_core #(
   parameter int NCH      = 4,
   parameter int WIDTH    = 16,
   parameter int DT_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   pwm_multich_core_if.slave bus,
   input  logic              fault_n,
   output logic [NCH-1:0]    pwm_h,
   output logic [NCH-1:0]    pwm_l,
   output logic              upd_irq
);

   logic                en, mode, dt_en;
   logic [15:0]         presc, psc_cnt;
   logic [WIDTH-1:0]    period_sh, period_act;
   logic [DT_WIDTH-1:0] deadtime, dt_load;
   logic [WIDTH-1:0]    duty_sh  [NCH];
   logic [WIDTH-1:0]    duty_act [NCH];
   logic [WIDTH-1:0]    cnt, cnt_nx;
   logic                dir, dir_nx;
   logic                tick, upd;
   logic [1:0]          sync;
   logic                flt, flt_nx;
   logic                wr_ctrl, fault_clr;
   logic [NCH-1:0]      wr_duty;
   logic [NCH-1:0]      raw, raw_q;
   logic [DT_WIDTH-1:0] dtcnt [NCH];
   logic [DT_WIDTH-1:0] dt_nx [NCH];
   logic [31:0]         rd_val;
   logic                unused_wdata;

   assign unused_wdata = ^bus.wdata;
   assign wr_ctrl      = bus.wr_en && bus.addr == 8'h00;
   assign fault_clr    = wr_ctrl && bus.wdata[3];
   assign flt_nx       = ~sync[1] | (flt & ~fault_clr);
   assign dt_load      = dt_en ? deadtime : '0;

   always_comb begin
      wr_duty = '0;
      for (int i = 0; i < NCH; i++)
         wr_duty[i] = bus.wr_en && bus.addr == 8'(16 + i);
   end

   always_comb begin
      tick   = en && psc_cnt >= presc;
      cnt_nx = cnt;
      dir_nx = dir;
      upd    = 1'b0;
      if (!en) begin
         cnt_nx = '0;
         dir_nx = 1'b0;
      end else if (!mode) begin
         dir_nx = 1'b0;
         if (tick) begin
            if (cnt >= period_act) begin
               cnt_nx = '0;
               upd    = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
      end else if (tick) begin
         // past the peak (or at it) the counter walks down to the valley
         if (dir || cnt >= period_act) begin
            cnt_nx = (cnt == '0) ? '0 : cnt - 1'b1;
            dir_nx = cnt_nx != '0;
            upd    = cnt_nx == '0;
         end else begin
            cnt_nx = cnt + 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         raw[i] = en && cnt < duty_act[i];
         if (raw[i] != raw_q[i])
            dt_nx[i] = dt_load;
         else if (dtcnt[i] != '0)
            dt_nx[i] = dtcnt[i] - 1'b1;
         else
            dt_nx[i] = '0;
      end
   end

   always_comb begin
      rd_val = '0;
      case (bus.addr)
         8'h00:   rd_val = {29'd0, dt_en, mode, en};
         8'h01:   rd_val = {16'd0, presc};
         8'h02:   rd_val = 32'(period_sh);
         8'h03:   rd_val = 32'(deadtime);
         8'h04:   rd_val = {30'd0, dir, flt};
         8'h05:   rd_val = 32'(cnt);
         default: rd_val = '0;
      endcase
      for (int i = 0; i < NCH; i++)
         if (bus.addr == 8'(16 + i))
            rd_val = 32'(duty_sh[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en        <= 1'b0;
         mode      <= 1'b0;
         dt_en     <= 1'b0;
         presc     <= '0;
         period_sh <= '0;
         deadtime  <= '0;
         for (int i = 0; i < NCH; i++)
            duty_sh[i] <= '0;
      end else begin
         if (wr_ctrl)
            {dt_en, mode, en} <= bus.wdata[2:0];
         if (bus.wr_en && bus.addr == 8'h01)
            presc <= bus.wdata[15:0];
         if (bus.wr_en && bus.addr == 8'h02)
            period_sh <= bus.wdata[WIDTH-1:0];
         if (bus.wr_en && bus.addr == 8'h03)
            deadtime <= bus.wdata[DT_WIDTH-1:0];
         for (int i = 0; i < NCH; i++)
            if (wr_duty[i])
               duty_sh[i] <= bus.wdata[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_cnt    <= '0;
         cnt        <= '0;
         dir        <= 1'b0;
         upd_irq    <= 1'b0;
         period_act <= '0;
         for (int i = 0; i < NCH; i++)
            duty_act[i] <= '0;
      end else begin
         psc_cnt <= (!en || tick) ? '0 : psc_cnt + 1'b1;
         cnt     <= cnt_nx;
         dir     <= dir_nx;
         upd_irq <= upd;
         // shadows see pre-write values here, so a coincident write waits
         if (!en || upd) begin
            period_act <= period_sh;
            for (int i = 0; i < NCH; i++)
               duty_act[i] <= duty_sh[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= 2'b11;
         flt        <= 1'b0;
         raw_q      <= '0;
         pwm_h      <= '0;
         pwm_l      <= '0;
         bus.rdata  <= '0;
         for (int i = 0; i < NCH; i++)
            dtcnt[i] <= '0;
      end else begin
         sync  <= {sync[0], fault_n};
         flt   <= flt_nx;
         raw_q <= raw;
         for (int i = 0; i < NCH; i++) begin
            dtcnt[i] <= dt_nx[i];
            pwm_h[i] <= raw[i] & (dt_nx[i] == '0) & ~flt_nx;
            pwm_l[i] <= ~raw[i] & en & (dt_nx[i] == '0) & ~flt_nx;
         end
         if (bus.rd_en)
            bus.rdata <= rd_val;
      end
   end

endmodule
